// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_sync input conditioner: FSM encodings
// and an elaboration-time helper for sizing the stability counter.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) = 0. Used only on constants at elaboration.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clock domain.
// Only stage 0 samples din; s is the last stage.
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic s
);

    logic [SYNC_STAGES-1:0] chain_reg;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        logic stage_in;

        if (gi == 0) begin : g_first
            assign stage_in = din;
        end else begin : g_rest
            assign stage_in = chain_reg[gi-1];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                chain_reg[gi] <= RESET_VAL;
            end else begin
                chain_reg[gi] <= stage_in;
            end
        end
    end

    assign s = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise, de-glitch and edge-detect a raw asynchronous input.
// q follows din only after STABLE_CYCLES consecutive disagreeing samples.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 10,
    parameter int   CNT_WIDTH     = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1 || CNT_WIDTH < clog2(STABLE_CYCLES)) begin : g_bad_cnt
        $error("debounce_sync: STABLE_CYCLES must be >= 1 and fit in 2**CNT_WIDTH");
    end

    // count holds the number of disagreeing samples already seen; the sample
    // that brings the total to STABLE_CYCLES commits the new level.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 s;
    state_t               state_reg,  state_next;
    logic [CNT_WIDTH-1:0] count_reg,  count_next;
    logic                 q_reg,      q_next;
    logic                 q_prev_reg;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (din),
        .s     (s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_STABLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg  <= '0;
            q_reg      <= RESET_VAL;
            q_prev_reg <= RESET_VAL;
        end else begin
            count_reg  <= count_next;
            q_reg      <= q_next;
            q_prev_reg <= q_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        q_next     = q_reg;
        case (state_reg)
            ST_STABLE: begin
                if (s != q_reg) begin
                    if (STABLE_CYCLES == 1) begin
                        q_next = s;
                    end else begin
                        state_next = ST_CHECK;
                        count_next = CNT_ONE;
                    end
                end
            end
            ST_CHECK: begin
                if (s == q_reg) begin
                    state_next = ST_STABLE;
                    count_next = '0;
                end else if (count_reg == CNT_LAST) begin
                    state_next = ST_STABLE;
                    count_next = '0;
                    q_next     = s;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_STABLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        q    = q_reg;
        busy = (state_reg == ST_CHECK);
        rise = q_reg & ~q_prev_reg;
        fall = ~q_reg & q_prev_reg;
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a default instance (a) and a
// STABLE_CYCLES=1 / SYNC_STAGES=3 instance (b) driven by directed vectors.
module tb_debounce_sync;

    localparam int SIG_Q_A     = 0;
    localparam int SIG_RISE_A  = 1;
    localparam int SIG_FALL_A  = 2;
    localparam int SIG_BUSY_A  = 3;
    localparam int SIG_BTOT_A  = 4;
    localparam int SIG_BTOT_B  = 5;
    localparam int SIG_PEND_A  = 6;
    localparam int SIG_PEND_B  = 7;
    localparam int SIG_Q_B     = 8;
    localparam int LAT_A       = 12;
    localparam int LAT_B       = 4;
    // Busy covers every disagreeing sample before the one that commits q.
    localparam int BUSY_EDGE_A = 9;

    typedef struct {
        int cyc;
        bit is_rise;
    } ev_t;

    typedef struct {
        int    at;
        int    sig;
        int    val;
        string name;
    } chk_t;

    logic clk;
    logic reset_a, din_a, q_a, rise_a, fall_a, busy_a;
    logic reset_b, din_b, q_b, rise_b, fall_b, busy_b;

    int   cyc = 0;
    int   busy_a_total = 0;
    int   busy_b_total = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_busy_a = 0;

    ev_t  exp_a[$];
    ev_t  exp_b[$];
    chk_t chk_q[$];

    debounce_sync dut_a (
        .clock (clk),
        .reset (reset_a),
        .din   (din_a),
        .q     (q_a),
        .rise  (rise_a),
        .fall  (fall_a),
        .busy  (busy_a)
    );

    debounce_sync #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (1),
        .CNT_WIDTH     (4),
        .RESET_VAL     (1'b0)
    ) dut_b (
        .clock (clk),
        .reset (reset_b),
        .din   (din_b),
        .q     (q_b),
        .rise  (rise_b),
        .fall  (fall_b),
        .busy  (busy_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input int sig);
        case (sig)
            SIG_Q_A:    return int'(q_a);
            SIG_RISE_A: return int'(rise_a);
            SIG_FALL_A: return int'(fall_a);
            SIG_BUSY_A: return int'(busy_a);
            SIG_BTOT_A: return busy_a_total;
            SIG_BTOT_B: return busy_b_total;
            SIG_PEND_A: return exp_a.size();
            SIG_PEND_B: return exp_b.size();
            SIG_Q_B:    return int'(q_b);
            default:    return -1;
        endcase
    endfunction

    task automatic judge_pulse(input string tag, input bit have, input ev_t ev,
                               input logic r, input logic f, input logic qv);
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s_unexpected_pulse: cycle %0d rise=%0b fall=%0b, required no pulse",
                     tag, cyc, r, f);
        end else if (cyc != ev.cyc || r != ev.is_rise || f == ev.is_rise || qv != ev.is_rise) begin
            n_fail++;
            $display("FAIL %s_pulse: cycle %0d rise=%0b fall=%0b q=%0b, required cycle %0d rise=%0b fall=%0b q=%0b",
                     tag, cyc, r, f, qv, ev.cyc, ev.is_rise, !ev.is_rise, ev.is_rise);
        end else begin
            $display("ok   %s_%s at cycle %0d", tag, ev.is_rise ? "rise" : "fall", cyc);
        end
    endtask

    // Monitor: consumes pulse expectations as pulses appear, and level checks when due.
    always @(negedge clk) begin
        ev_t  ev;
        chk_t c;
        int   v;
        bit   have;
        if (busy_a) busy_a_total++;
        if (busy_b) busy_b_total++;
        if (rise_a || fall_a) begin
            have = (exp_a.size() > 0);
            ev   = '{0, 1'b0};
            if (have) ev = exp_a.pop_front();
            judge_pulse("a", have, ev, rise_a, fall_a, q_a);
        end
        if (rise_b || fall_b) begin
            have = (exp_b.size() > 0);
            ev   = '{0, 1'b0};
            if (have) ev = exp_b.pop_front();
            judge_pulse("b", have, ev, rise_b, fall_b, q_b);
        end
        while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
            c = chk_q.pop_front();
            v = sample(c.sig);
            n_checks++;
            if (v != c.val) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got %0d, required %0d", c.name, cyc, v, c.val);
            end else begin
                $display("ok   %s at cycle %0d = %0d", c.name, cyc, v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int at, input int sig, input int val, input string name);
        chk_q.push_back('{at, sig, val, name});
    endtask

    task automatic settle_a(input int qv, input string tag);
        expect_at(cyc + 1, SIG_Q_A,    qv,         {tag, "_q"});
        expect_at(cyc + 1, SIG_BTOT_A, exp_busy_a, {tag, "_busy_cycles"});
        expect_at(cyc + 1, SIG_PEND_A, 0,          {tag, "_pulses_outstanding"});
        tick(2);
    endtask

    task automatic edge_a(input logic level, input string tag);
        din_a = level;
        exp_a.push_back('{cyc + LAT_A, level});
        exp_busy_a += BUSY_EDGE_A;
        tick(LAT_A + 4);
        settle_a(int'(level), tag);
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        din_a   = 1'b1;
        din_b   = 1'b0;

        // Reset held for two edges with din_a=1.
        expect_at(2, SIG_Q_A,    0, "reset_q");
        expect_at(2, SIG_RISE_A, 0, "reset_rise");
        expect_at(2, SIG_FALL_A, 0, "reset_fall");
        expect_at(2, SIG_BUSY_A, 0, "reset_busy");
        expect_at(2, SIG_Q_B,    0, "reset_q_b");
        tick(2);

        // Release with din_a already high: q stays low one edge, rises 12 edges on.
        reset_a = 1'b0;
        reset_b = 1'b0;
        expect_at(cyc + 1, SIG_Q_A, 0, "q_after_release");
        exp_a.push_back('{cyc + LAT_A, 1'b1});
        exp_busy_a += BUSY_EDGE_A;
        tick(LAT_A + 4);
        settle_a(1, "release_rise");

        edge_a(1'b0, "clean_fall");

        // Five-cycle glitch: busy for 5 cycles, q untouched.
        din_a = 1'b1;
        tick(5);
        din_a = 1'b0;
        exp_busy_a += 5;
        tick(20);
        settle_a(0, "glitch5");

        // Nine-cycle glitch: one sample short of committing.
        din_a = 1'b1;
        tick(9);
        din_a = 1'b0;
        exp_busy_a += 9;
        tick(20);
        settle_a(0, "glitch9");

        edge_a(1'b1, "clean_rise");
        edge_a(1'b0, "clean_fall2");

        // Reset lands on the 6th edge after din rises; pending count is discarded.
        din_a = 1'b1;
        tick(5);
        reset_a = 1'b1;
        expect_at(cyc + 1, SIG_Q_A,    0, "midreset_q");
        expect_at(cyc + 1, SIG_BUSY_A, 0, "midreset_busy");
        exp_busy_a += 3;
        tick(1);
        reset_a = 1'b0;
        exp_a.push_back('{cyc + LAT_A, 1'b1});
        exp_busy_a += BUSY_EDGE_A;
        tick(LAT_A + 4);
        settle_a(1, "midreset_rise");

        // Instance b: single-sample commit through a three-flop chain.
        din_b = 1'b1;
        exp_b.push_back('{cyc + LAT_B, 1'b1});
        tick(LAT_B + 4);
        expect_at(cyc + 1, SIG_Q_B, 1, "b_q_high");
        tick(2);
        din_b = 1'b0;
        exp_b.push_back('{cyc + LAT_B, 1'b0});
        tick(LAT_B + 4);
        expect_at(cyc + 1, SIG_Q_B,    0, "b_q_low");
        expect_at(cyc + 1, SIG_BTOT_B, 0, "b_busy_cycles");
        expect_at(cyc + 1, SIG_PEND_B, 0, "b_pulses_outstanding");
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
